// File: rtl/image_byte_buffer.sv
// image_byte_buffer
// Assembles the serial image bit stream into bytes and queues them in a
// first-word-fall-through FIFO drained through a valid/ready handshake.
// Completed bytes that find the FIFO full (with no pop that cycle) are
// dropped and flagged by the sticky overflow output.
//
// Build option: define IMAGE_BYTE_BUFFER_MSB_FIRST_EN to place the first
// received bit of each byte at bit 7 instead of bit 0.
module image_byte_buffer #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  input_bit,
  input  logic                  is_new_input_bit,
  input  logic                  flush,
  output logic [7:0]            out_byte,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PW    = DEPTH_LOG2 + 1;

  logic [2:0]    bit_idx_reg, bit_idx_next;
  logic [7:0]    shreg_reg, shreg_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic          overflow_reg, overflow_next;
  logic [7:0]    mem [DEPTH];

  logic [2:0]    bit_pos;
  logic [7:0]    byte_next;
  logic          byte_done;
  logic          empty;
  logic          pop;
  logic          push;
  logic          drop;

  // Bit placement order and the completed byte depend on the build option.
`ifdef IMAGE_BYTE_BUFFER_MSB_FIRST_EN
  assign bit_pos   = 3'd7 - bit_idx_reg;
  assign byte_next = {shreg_reg[7:1], input_bit};
`else
  assign bit_pos   = bit_idx_reg;
  assign byte_next = {input_bit, shreg_reg[6:0]};
`endif

  // Pointer-derived FIFO status; the extra pointer MSB disambiguates full/empty.
  assign empty     = (wr_ptr_reg == rd_ptr_reg);
  assign full      = (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_reg[DEPTH_LOG2-1:0]) &&
                     (wr_ptr_reg[DEPTH_LOG2] != rd_ptr_reg[DEPTH_LOG2]);
  assign level     = wr_ptr_reg - rd_ptr_reg;
  assign out_valid = !empty;
  assign overflow  = overflow_reg;
  assign out_byte  = mem[rd_ptr_reg[DEPTH_LOG2-1:0]];

  // flush overrides everything, so it masks both the handshake and the push.
  assign byte_done = is_new_input_bit && (bit_idx_reg == 3'd7);
  assign pop       = out_valid && out_ready && !flush;
  assign push      = byte_done && !flush && (!full || pop);
  assign drop      = byte_done && !flush && full && !pop;

  // Each shreg bit captures input_bit only when it is the current target position.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_shreg
      assign shreg_next[gi] = flush ? 1'b0 :
                              (is_new_input_bit && (bit_pos == 3'(gi))) ? input_bit :
                              shreg_reg[gi];
    end
  endgenerate

  // Next-state for bit counter, pointers and the sticky overflow flag.
  always_comb begin
    bit_idx_next  = bit_idx_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    overflow_next = overflow_reg;
    if (flush) begin
      bit_idx_next  = 3'd0;
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      overflow_next = 1'b0;
    end else begin
      if (is_new_input_bit) begin
        bit_idx_next = bit_idx_reg + 3'd1;
      end
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PW'(1);
      end
      if (drop) begin
        overflow_next = 1'b1;
      end
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_idx_reg  <= 3'd0;
      shreg_reg    <= 8'd0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      overflow_reg <= 1'b0;
    end else begin
      bit_idx_reg  <= bit_idx_next;
      shreg_reg    <= shreg_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      overflow_reg <= overflow_next;
    end
  end

  // Storage array; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= byte_next;
    end
  end

endmodule

// File: tb/tb_image_byte_buffer.sv
// Testbench for image_byte_buffer: directed scenarios followed by random
// traffic, all checked against a queue-based behavioural model.
module tb_image_byte_buffer;

  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rst;
  logic          input_bit;
  logic          is_new_input_bit;
  logic          flush;
  logic [7:0]    out_byte;
  logic          out_valid;
  logic          out_ready;
  logic          full;
  logic [DL:0]   level;
  logic          overflow;

  image_byte_buffer #(.DEPTH_LOG2(DL)) dut (
    .clk              (clk),
    .rst              (rst),
    .input_bit        (input_bit),
    .is_new_input_bit (is_new_input_bit),
    .flush            (flush),
    .out_byte         (out_byte),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .full             (full),
    .level            (level),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: bytes in flight, partial byte as a bit count and value.
  logic [7:0] q[$];
  int         pcount;
  logic [7:0] pbyte;
  logic       m_ovf;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pcount = 0;
    pbyte  = 8'd0;
    m_ovf  = 1'b0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input logic nb, input logic b, input logic rdy, input logic fl);
    logic       done;
    logic       do_pop;
    logic [7:0] done_byte;
    int         pos;
    done      = 1'b0;
    done_byte = 8'd0;
    if (fl) begin
      model_reset();
      return;
    end
    do_pop = (q.size() > 0) && rdy;
    if (nb) begin
`ifdef IMAGE_BYTE_BUFFER_MSB_FIRST_EN
      pos = 7 - pcount;
`else
      pos = pcount;
`endif
      if (b) pbyte = pbyte | (8'd1 << pos);
      pcount++;
      if (pcount == 8) begin
        done      = 1'b1;
        done_byte = pbyte;
        pcount    = 0;
        pbyte     = 8'd0;
      end
    end
    if (do_pop) begin
      $display("pop byte=%02h level_before=%0d", q[0], q.size());
      void'(q.pop_front());
    end
    if (done) begin
      if (q.size() < DEPTH) q.push_back(done_byte);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'(q.size() > 0));
    chk({tag, "_level"}, 32'(level), 32'(q.size()));
    chk({tag, "_full"}, 32'(full), 32'(q.size() == DEPTH));
    chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    if (q.size() > 0) chk({tag, "_byte"}, 32'(out_byte), 32'(q[0]));
  endtask

  task automatic cyc(input logic nb, input logic b, input logic rdy, input logic fl);
    is_new_input_bit = nb;
    input_bit        = b;
    out_ready        = rdy;
    flush            = fl;
    @(posedge clk);
    model_edge(nb, b, rdy, fl);
    #1;
    check_all("cyc");
  endtask

  // Serialise a byte in the build's bit order so it reassembles to the same value.
  task automatic send_byte(input logic [7:0] b, input int gap, input logic rdy_last);
    logic bitv;
    for (int i = 0; i < 8; i++) begin
`ifdef IMAGE_BYTE_BUFFER_MSB_FIRST_EN
      bitv = b[7-i];
`else
      bitv = b[i];
`endif
      cyc(1'b1, bitv, (i == 7) ? rdy_last : 1'b0, 1'b0);
      if (i < 7) begin
        for (int g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (q.size() > 0) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] raw;
    rst = 1'b1; input_bit = 1'b0; is_new_input_bit = 1'b0; flush = 1'b0; out_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single byte and its pop.
    send_byte(8'hA5, 0, 1'b0);
    chk("a5_byte", 32'(out_byte), 32'hA5);
    chk("a5_level", 32'(level), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("a5_popped_valid", 32'(out_valid), 32'd0);
    chk("a5_popped_level", 32'(level), 32'd0);

    // Gapped input.
    send_byte(8'h3C, 3, 1'b0);
    chk("gap_byte", 32'(out_byte), 32'h3C);
    drain();

    // Fill, overflow, ordered drain.
    for (int i = 0; i < DEPTH; i++) send_byte(8'(i), 0, 1'b0);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'(DEPTH));
    chk("fill_ovf", 32'(overflow), 32'd0);
    send_byte(8'hFF, 0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      chk("drain_order", 32'(out_byte), 32'(i));
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Push and pop in the same cycle while full.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("flush_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h10 + i), 0, 1'b0);
    send_byte(8'h77, 0, 1'b1);
    chk("pp_ovf", 32'(overflow), 32'd0);
    chk("pp_level", 32'(level), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("pp_last", 32'(out_byte), 32'h77);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
    end

    // flush mid-byte.
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    send_byte(8'h81, 0, 1'b0);
    chk("flush_mid_byte", 32'(out_byte), 32'h81);
    drain();

    // Asynchronous reset mid-byte with data queued.
    send_byte(8'h42, 0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    is_new_input_bit = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_full", 32'(full), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h81, 0, 1'b0);
    chk("rst_mid_byte", 32'(out_byte), 32'h81);
    drain();

    // Raw bit order 1,1,0,0,0,0,0,0.
    raw = 8'b0000_0011;
    for (int i = 0; i < 8; i++) cyc(1'b1, raw[i], 1'b0, 1'b0);
`ifdef IMAGE_BYTE_BUFFER_MSB_FIRST_EN
    chk("order_byte", 32'(out_byte), 32'hC0);
`else
    chk("order_byte", 32'(out_byte), 32'h03);
`endif
    drain();

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      cyc(($urandom % 4) != 0, 1'($urandom), ($urandom % 3) == 0, ($urandom % 250) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/image_byte_buffer.md
# image_byte_buffer

Downstream of the packet parser. Collects the serial image bit stream (`output_bit` / `is_new_output_bit`) into 8-bit bytes and queues them in a first-word-fall-through FIFO. The JPEG decoder front end drains the FIFO through a valid/ready handshake. The block absorbs the rate mismatch between the serial link and the decoder, and flags any bytes lost to overflow.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 bytes (16). Legal range is 1..10.

Ports:
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `input_bit` in 1: serial image data bit from the packet parser.
- `is_new_input_bit` in 1: qualifies `input_bit`; one bit is consumed per cycle while high.
- `flush` in 1: synchronous clear of the partial byte, the FIFO and `overflow`.
- `out_byte` out 8: head-of-FIFO byte; valid only while `out_valid` is high.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer accepts `out_byte` when both `out_valid` and `out_ready` are high.
- `full` out 1: FIFO holds 2^DEPTH_LOG2 bytes.
- `level` out DEPTH_LOG2+1: current byte count, 0..2^DEPTH_LOG2.
- `overflow` out 1: sticky; set when a completed byte is dropped.

## Operation
- **Bit assembly**
  - A 3-bit `bit_idx` counts 0..7 and wraps 7→0.
  - An 8-bit `shreg` holds the partial byte.
  - On each cycle with `is_new_input_bit`=1, `input_bit` is stored at position `bit_idx`. The first bit received goes to bit 0 (LSB-first), matching the parser's command/header bit order.
- **Byte completion**
  - A byte completes when `is_new_input_bit`=1 and `bit_idx`=7.
  - The completed byte is `{input_bit, shreg[6:0]}`. It is pushed on that same edge, and `bit_idx` returns to 0.
- **Push**
  - If the FIFO is not full, the byte is written to `mem[wr_ptr]` and `wr_ptr` increments.
  - If the FIFO is full and no pop occurs that cycle, the byte is dropped and `overflow` is set to 1. `overflow` stays set until `rst` or `flush`.
- **Pop**
  - A pop occurs when `out_valid`&&`out_ready`; `rd_ptr` increments.
  - `out_byte` = `mem[rd_ptr]` combinationally (FWFT).
- **Simultaneous push and pop**
  - Both take effect and `level` is unchanged.
  - This includes the full case: a pop frees the slot in the same cycle, so the push is accepted and `overflow` is not set.
- **Pointers**
  - `wr_ptr`/`rd_ptr` are DEPTH_LOG2+1 bits wide; the extra MSB is a wrap bit.
  - `full` when the addresses are equal and the wrap bits differ.
  - Empty when the pointers are equal.
  - `level` = `wr_ptr` − `rd_ptr`, modulo 2^(DEPTH_LOG2+1).
- **flush**
  - Has priority over every other input in the cycle it is high.
  - Clears `bit_idx`, `shreg`, both pointers and `overflow`.
  - Any bit presented in the same cycle is discarded.
- No knowledge of packet boundaries; a trailing partial byte stays in `shreg` until it is completed or cleared by `flush`/`rst`.

## Timing
- **Reset values** (asynchronous, immediate on `rst`=1):
  - `out_valid`=0, `full`=0, `level`=0, `overflow`=0.
  - `out_byte` is don't-care because `out_valid`=0.
  - `bit_idx`=0, `shreg`=0, pointers=0.
- **Reset release:** the first edge after `rst` falls may accept a bit.
- **Latency:**
  - 8th bit sampled at edge N → `out_valid`=1 and `out_byte` correct during cycle N+1, when the FIFO was empty.
  - `level` and `full` update at the same edge as the push or pop.
- **Throughput:** one bit per cycle in; one byte per cycle out.
- **Mid-byte reset:** the partial byte is lost, and reassembly restarts at bit 0.
- **Handshake stability:**
  - `out_byte` is stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` only falls after a pop empties the FIFO, or on `flush`/`rst`.

## Configuration
- Macro: `IMAGE_BYTE_BUFFER_MSB_FIRST_EN`.
- **Defined:** the first received bit goes to bit 7. `bit_idx` selects position 7−`bit_idx`, and the completed byte is `{shreg[7:1], input_bit}`.
- **Undefined (default):** LSB-first as described in Operation.
- All other behaviour is identical in both builds.

## Test plan
- **Single byte:** after reset, send bits 1,0,1,0,0,1,0,1 on consecutive cycles → during the cycle after the 8th bit, `out_valid`=1, `out_byte`=8'hA5, `level`=1. One cycle with `out_ready`=1 → `out_valid`=0, `level`=0.
- **Gapped input:** send the 8 bits of 8'h3C with `is_new_input_bit` low for 3 cycles between bits → `out_byte`=8'h3C. No byte appears before the 8th valid bit.
- **Fill and overflow:** with `out_ready`=0 and DEPTH_LOG2=4, push 16 bytes 8'h00..8'h0F → `full`=1, `level`=16, `overflow`=0. Push a 17th byte (8'hFF) → `overflow`=1 and `level` stays 16. Drain → 8'h00..8'h0F in order; 8'hFF never appears.
- **Push and pop while full:** while full, complete a byte 8'h77 in the same cycle as a pop → `overflow` stays 0, `level` stays 16, and 8'h77 emerges last.
- **Flush and reset mid-byte:**
  - Send 5 bits, assert `flush`, then send the 8 bits of 8'h81 → first output is 8'h81.
  - Repeat with `rst` asserted asynchronously between clock edges instead of `flush` → same result; outputs clear immediately on `rst`.
- **MSB-first build:** define `IMAGE_BYTE_BUFFER_MSB_FIRST_EN` and send bits 1,0,1,0,0,1,0,1 → `out_byte`=8'hA5. Send 1,1,0,0,0,0,0,0 → 8'hC0 (the LSB-first build gives 8'h03).
